// File: rtl/sw_logic_eval_pkg.sv
// rtl/sw_logic_eval_pkg.sv - mode codes shared by the switch logic evaluator
package sw_logic_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd3;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

  // Highest code the mode register reaches before wrapping to AND
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_XNOR;

endpackage

// File: rtl/sw_logic_eval_if.sv
// rtl/sw_logic_eval_if.sv - board-side signal bundle of the switch logic evaluator
interface sw_logic_eval_if #(
  parameter int N_IN = 4
);
  import sw_logic_pkg::*;

  logic [N_IN-1:0]   sw_in;
  logic              key_mode;
  logic              f_out;
  logic              f_chg;
  logic [MODE_W-1:0] mode_out;

  // Board/stimulus side: drives raw switches and key, observes LEDs
  modport master (
    output sw_in,
    output key_mode,
    input  f_out,
    input  f_chg,
    input  mode_out
  );

  // Evaluator side
  modport slave (
    input  sw_in,
    input  key_mode,
    output f_out,
    output f_chg,
    output mode_out
  );

endinterface

// File: rtl/sw_logic_eval_debounce.sv
// rtl/sw_logic_eval_debounce.sv - one-channel 2-flop synchroniser plus stability counter
module sw_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic dout_o
);

  // At least one counter bit even when DEB_CYCLES is 1
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, debounced level and counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o = deb_q;

endmodule

// File: rtl/sw_logic_eval.sv
// rtl/sw_logic_eval.sv - debounced switches reduced by a key-selected logic function
module sw_logic_eval
  import sw_logic_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  sw_logic_eval_if.slave bus
);

  logic [N_IN-1:0]   deb_sw;
  logic              key_deb;
  logic              key_prev_q;
  logic              key_rise;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic              f_nxt;
  logic              f_out_q;
  logic              f_chg_q;

  // Switch channels occupy 0..N_IN-1, the mode key is the extra channel
  for (genvar g = 0; g <= N_IN; g++) begin : g_deb
    if (g < N_IN) begin : g_sw
      sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .din_i  (bus.sw_in[g]),
        .dout_o (deb_sw[g])
      );
    end else begin : g_key
      sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .din_i  (bus.key_mode),
        .dout_o (key_deb)
      );
    end
  end

  assign key_rise = key_deb & ~key_prev_q;

  // Step the mode on each debounced press, wrapping after XNOR
  always_comb begin
    mode_d = mode_q;
    if (key_rise) begin
      mode_d = (mode_q >= MODE_LAST) ? MODE_AND : mode_q + MODE_W'(1);
    end
  end

  // Reduction selected by the current (registered) mode
  always_comb begin
    f_nxt = 1'b0;
    case (mode_q)
      MODE_AND:  f_nxt =   &deb_sw;
      MODE_OR:   f_nxt =   |deb_sw;
      MODE_XOR:  f_nxt =   ^deb_sw;
      MODE_NAND: f_nxt = ~(&deb_sw);
      MODE_NOR:  f_nxt = ~(|deb_sw);
      MODE_XNOR: f_nxt = ~(^deb_sw);
      default:   f_nxt =   &deb_sw;
    endcase
  end

  // Mode register, key edge history and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_prev_q <= 1'b0;
      mode_q     <= MODE_AND;
      f_out_q    <= 1'b0;
      f_chg_q    <= 1'b0;
    end else begin
      key_prev_q <= key_deb;
      mode_q     <= mode_d;
      f_out_q    <= f_nxt;
      f_chg_q    <= (f_nxt != f_out_q);
    end
  end

  assign bus.f_out    = f_out_q;
  assign bus.f_chg    = f_chg_q;
  assign bus.mode_out = mode_q;

endmodule

// File: tb/tb_sw_logic_eval.sv
// tb/tb_sw_logic_eval.sv - directed scoreboard bench for sw_logic_eval
module tb_sw_logic_eval;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   chg_cnt;
  logic [7:0] exp_q[$];

  sw_logic_eval_if #(.N_IN(4)) bus ();

  sw_logic_eval #(.N_IN(4), .DEB_CYCLES(4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1);
  end

  // Advance one clock and sample 1 ns after the edge, tallying f_chg pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.f_chg === 1'b1) chg_cnt++;
  endtask

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %0h, scoreboard had no expected value", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic press();
    bus.key_mode = 1'b1;
    repeat (10) tick();
    bus.key_mode = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    logic [7:0] exp_mode [6];
    logic [7:0] exp_f    [6];
    exp_mode = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    exp_f    = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    total    = 0;
    bad      = 0;
    chg_cnt  = 0;

    // 1: reset state and first-result latency with all switches on
    rst_n        = 1'b0;
    bus.sw_in    = 4'hF;
    bus.key_mode = 1'b0;
    push(8'd0); push(8'd0); push(8'd0);
    tick(); tick();
    check("rst_f_out", 8'(bus.f_out));
    check("rst_mode", 8'(bus.mode_out));
    check("rst_f_chg", 8'(bus.f_chg));
    rst_n   = 1'b1;
    chg_cnt = 0;
    push(8'd0);
    repeat (6) tick();
    check("lat_f_out_edge6", 8'(bus.f_out));
    push(8'd1); push(8'd1);
    tick();
    check("lat_f_out_edge7", 8'(bus.f_out));
    check("lat_f_chg_edge7", 8'(bus.f_chg));
    push(8'd1); push(8'd0);
    repeat (5) tick();
    check("lat_chg_count", 8'(chg_cnt));
    check("lat_mode", 8'(bus.mode_out));

    // 2: three-clock glitch on bit0 must be filtered
    chg_cnt   = 0;
    bus.sw_in = 4'hE;
    push(8'd1); push(8'd0);
    repeat (3) tick();
    bus.sw_in = 4'hF;
    repeat (12) tick();
    check("glitch_f_out", 8'(bus.f_out));
    check("glitch_chg_count", 8'(chg_cnt));

    // 3: 0101 under AND, then two presses to XOR, then NAND with exact timing
    bus.sw_in = 4'b0101;
    push(8'd0);
    repeat (10) tick();
    check("and_0101", 8'(bus.f_out));
    chg_cnt = 0;
    push(8'd2); push(8'd0); push(8'd2);
    press();
    press();
    check("xor_mode", 8'(bus.mode_out));
    check("xor_f_out", 8'(bus.f_out));
    check("xor_chg_count", 8'(chg_cnt));
    chg_cnt      = 0;
    bus.key_mode = 1'b1;
    push(8'd2);
    repeat (6) tick();
    check("nand_mode_edge6", 8'(bus.mode_out));
    push(8'd3); push(8'd0);
    tick();
    check("nand_mode_edge7", 8'(bus.mode_out));
    check("nand_f_out_edge7", 8'(bus.f_out));
    push(8'd1); push(8'd1);
    tick();
    check("nand_f_out_edge8", 8'(bus.f_out));
    check("nand_f_chg_edge8", 8'(bus.f_chg));
    repeat (2) tick();
    bus.key_mode = 1'b0;
    push(8'd1);
    repeat (10) tick();
    check("nand_chg_count", 8'(chg_cnt));

    // 4: from reset, six presses walk 1..5 then wrap to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(exp_mode[i]);
      push(exp_f[i]);
      press();
      check($sformatf("wrap_mode_%0d", i), 8'(bus.mode_out));
      check($sformatf("wrap_f_out_%0d", i), 8'(bus.f_out));
    end

    // 5: key and switch debounced on the same clock -> no intermediate value
    bus.sw_in = 4'b0001;
    push(8'd0); push(8'd0);
    repeat (10) tick();
    check("sim_pre_f_out", 8'(bus.f_out));
    check("sim_pre_mode", 8'(bus.mode_out));
    chg_cnt      = 0;
    bus.key_mode = 1'b1;
    tick();
    bus.sw_in    = 4'b0000;
    push(8'd1); push(8'd0); push(8'd0);
    repeat (9) tick();
    bus.key_mode = 1'b0;
    repeat (10) tick();
    check("sim_mode", 8'(bus.mode_out));
    check("sim_f_out", 8'(bus.f_out));
    check("sim_chg_count", 8'(chg_cnt));

    // 6: reset mid-debounce while in NOR, then recovery with all switches on
    press(); press(); press();
    push(8'd4); push(8'd1);
    check("nor_mode", 8'(bus.mode_out));
    check("nor_f_out", 8'(bus.f_out));
    bus.sw_in = 4'hF;
    repeat (3) tick();
    rst_n = 1'b0;
    push(8'd0); push(8'd0); push(8'd0);
    #1;
    check("midrst_f_out", 8'(bus.f_out));
    check("midrst_mode", 8'(bus.mode_out));
    check("midrst_f_chg", 8'(bus.f_chg));
    tick(); tick();
    rst_n   = 1'b1;
    chg_cnt = 0;
    push(8'd0);
    repeat (6) tick();
    check("rec_f_out_edge6", 8'(bus.f_out));
    push(8'd1);
    tick();
    check("rec_f_out_edge7", 8'(bus.f_out));
    push(8'd1); push(8'd0);
    repeat (3) tick();
    check("rec_chg_count", 8'(chg_cnt));
    check("rec_mode", 8'(bus.mode_out));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
